// File: rtl/arm_pipe_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | arm_pipe_pkg : shared types/constants for the MEM-stage SRAM path |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
package arm_pipe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } sram_state_t;

   localparam int unsigned DATA_MEM_BASE   = 1024;
   localparam int unsigned SRAM_AW_DEFAULT = 18;

   // 32-bit word index relative to the data-memory base; wraps silently.
   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_phase_counter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | sram_phase_counter : per-half access cycle counter with TC flag   |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module sram_phase_counter #(
   parameter int HALF_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tc
);

   localparam int              CW     = $clog2(HALF_CYCLES);
   localparam logic [CW-1:0]   c_last = CW'(HALF_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   assign o_tc = (r_cnt == c_last);

   // Wraps to zero on terminal count so LOW hands HIGH a fresh phase.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_stage_sram_ctrl : 32-bit load/store as two 16-bit SRAM halves |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module mem_stage_sram_ctrl
   import arm_pipe_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'(DATA_MEM_BASE),
   parameter int          HALF_CYCLES = 3,
   parameter int          SRAM_AW     = int'(SRAM_AW_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int c_hw = SRAM_AW - 1;

   sram_state_t       r_state;
   sram_state_t       w_next;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic              r_is_wr;
   logic [31:0]       r_rdata;
   logic              w_req;
   logic              w_tc;
   logic              w_in_half;
   logic [c_hw-1:0]   w_word;

   assign w_req     = rd_en | wr_en;
   assign w_in_half = (r_state == LOW) || (r_state == HIGH);
   assign w_word    = c_hw'(word_index(r_addr, BASE_ADDR));
   assign ready     = ((r_state == IDLE) && !w_req) || (r_state == DONE);
   assign read_data = r_rdata;

   sram_phase_counter #(
      .HALF_CYCLES (HALF_CYCLES)
   ) u_phase (
      .clk     (clk),
      .rst     (rst),
      .i_clear (!w_in_half),
      .i_en    (w_in_half),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_is_wr <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == IDLE) && w_req) begin
            r_addr  <= address;
            r_wdata <= write_data;
            r_is_wr <= wr_en;
         end
         // Capture on the last cycle of each half, when the SRAM data has settled.
         if (!r_is_wr && w_tc) begin
            if (r_state == LOW) begin
               r_rdata[15:0] <= sram_dq_in;
            end else if (r_state == HIGH) begin
               r_rdata[31:16] <= sram_dq_in;
            end
         end
      end
   end

   // we_n rises on the terminal cycle while address and data are still held.
   always_comb begin
      w_next      = r_state;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_next = LOW;
            end
         end
         LOW: begin
            sram_addr = {w_word, 1'b0};
            if (r_is_wr) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = r_wdata[15:0];
               sram_we_n   = w_tc;
            end
            if (w_tc) begin
               w_next = HIGH;
            end
         end
         HIGH: begin
            sram_addr = {w_word, 1'b1};
            if (r_is_wr) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = r_wdata[31:16];
               sram_we_n   = w_tc;
            end
            if (w_tc) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- MEM-stage data-memory controller. It sits between the EXE/MEM pipeline register and the MEM/WB stage register.
- Turns a 32-bit load/store from the pipeline into two 16-bit accesses on an external asynchronous SRAM.
- Drives `ready` low to freeze the whole pipeline until the access completes.
- Supplies `read_data` to the MEM/WB register's data-memory input.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- HALF_CYCLES, 3: clock cycles spent on each 16-bit half access; must be ≥ 2.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1: pipeline clock, rising edge.
- rst  in  1: reset; synchronous, active-high.
- rd_en  in  1: load request from MEM stage.
- wr_en  in  1: store request from MEM stage.
- address  in  32: byte address (ALU result).
- write_data  in  32: store data (Rm value).
- read_data  out  32: load result, registered, to MEM/WB register.
- ready  out  1: 1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW: SRAM halfword address.
- sram_dq_out  out  16: write data to SRAM.
- sram_dq_in  in  16: read data from SRAM.
- sram_dq_oe  out  1: 1 = controller drives the DQ bus (top-level tristate uses it).
- sram_we_n  out  1: SRAM write enable, active-low.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high. All state changes on rising clk. rst overrides everything, including mid-transaction; the pending transaction is abandoned.
- Reset values:
  - state=IDLE, cnt=0, read_data=0.
  - Latched address/data/op = 0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address map:
  - word = (address − BASE_ADDR) >> 2, computed in 32-bit, truncated (out-of-range addresses wrap, no error).
  - Low half uses sram_addr = {word[SRAM_AW−2:0], 1'b0}; high half uses {word[SRAM_AW−2:0], 1'b1}.
- Op select: req = rd_en | wr_en. When both are set, treat as a write.
- States: IDLE, LOW, HIGH, DONE; phase counter cnt.
- IDLE:
  - If req: latch address, write_data and op; go to LOW with cnt=0.
  - Otherwise stay.
- LOW:
  - Drive the low-half sram_addr.
  - Write: sram_dq_oe=1, sram_dq_out=wdata[15:0], sram_we_n=0 for cnt < HALF_CYCLES−1, and 1 at cnt = HALF_CYCLES−1. Address and data stay stable across the we_n rising edge.
  - Read: oe=0, we_n=1; on the cycle with cnt = HALF_CYCLES−1, capture sram_dq_in into read_data[15:0].
  - When cnt = HALF_CYCLES−1: go to HIGH with cnt=0; otherwise cnt+1.
- HIGH: identical to LOW with the high-half address, wdata[31:16] and read_data[31:16]. Exit to DONE.
- DONE: SRAM idle (oe=0, we_n=1); go to IDLE.
- ready (combinational): (state==IDLE && !req) || state==DONE.
- Latency: request first sampled in IDLE at cycle 0 → LOW cycles 1..H, HIGH cycles H+1..2H, DONE at cycle 2H+1 (cycle 7 at default H=3). The pipeline advances on the edge ending DONE.
- Request dropped mid-transaction: the transaction still completes (a write is never partially aborted). ready stays 0 until DONE.
- Back-to-back: a request present in IDLE right after DONE belongs to the next instruction and starts a new transaction. IDLE therefore costs one cycle per access.
- read_data:
  - Write transactions leave read_data unchanged.
  - Holds its value outside reads.
  - During a read, read_data[15:0] is updated at the end of LOW; the word is only valid in DONE and after.

Decomposition:
- Shared package `arm_pipe_pkg`:
  - sram_state_t enum {IDLE, LOW, HIGH, DONE}.
  - DATA_MEM_BASE = 1024 constant.
  - SRAM_AW default.
- One natural sub-module: `sram_phase_counter` (cnt with load/terminal-count flag), parameterised by HALF_CYCLES.
- Everything else stays in this block.

Test Plan:
- Reset, no request → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0 held for 10 cycles.
- wr_en=1, address=1024, write_data=0xDEADBEEF, H=3:
  - sram_addr=0 with dq_out=0xBEEF, we_n low 2 cycles.
  - Then sram_addr=1 with dq_out=0xDEAD, we_n low 2 cycles.
  - ready=1 only at cycle 7.
- rd_en=1, address=1028, SRAM model holding halfwords 2=0x5678, 3=0x1234 → read_data=0x12345678 in DONE; ready low cycles 0–6.
- Back-to-back store to 1032 then load from 1032 (requests held until ready) → load returns the stored word; second transaction starts the cycle after DONE.
- rst asserted in HIGH of a write → next cycle state IDLE, we_n=1, oe=0, ready=1 (with req low). A subsequent read works normally.
- rd_en and wr_en both 1, address=1040 → performs the write; read_data unchanged.
